// File: rtl/addr_data_pkg.sv
// Shared address/data pair type used by the FIFO and the neighbouring register stage.
// ADDR_W/DATA_W on the FIFO must not exceed the package widths below.
package addr_data_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } addr_data_t;

  localparam addr_data_t ADDR_DATA_ZERO = '0;

endpackage : addr_data_pkg

// File: rtl/addr_data_mem.sv
// DEPTH x addr_data_t storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; the FIFO's occupancy decides what is valid.
module addr_data_mem
  import addr_data_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  addr_data_t               wr_entry,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output addr_data_t               rd_entry
);

  addr_data_t mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr] <= wr_entry;
    end
  end

  // Read is combinational so the head entry is visible the edge after it is written.
  assign rd_entry = mem_reg[rd_ptr];

endmodule : addr_data_mem

// File: rtl/addr_data_fifo.sv
// Address/data FIFO with valid/ready on both sides, occupancy count and a sticky
// overflow-attempt flag. Flags derive only from the registered count.
module addr_data_fifo
  import addr_data_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err,
  input  logic                     clr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             push, pop;
  addr_data_t       wr_entry, rd_entry;

  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_entry      = ADDR_DATA_ZERO;
    wr_entry.addr = ADDR_W_DEF'(in_addr);
    wr_entry.data = DATA_W_DEF'(in_data);
  end

  addr_data_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .wr_en    (push),
    .wr_ptr   (wr_ptr_reg),
    .wr_entry (wr_entry),
    .rd_ptr   (rd_ptr_reg),
    .rd_entry (rd_entry)
  );

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase

    // A fresh overflow attempt outranks a clear in the same cycle.
    if (in_valid && !in_ready) begin
      ovf_next = 1'b1;
    end else if (clr_err) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Stale storage is hidden whenever the FIFO is empty.
  assign out_addr = out_valid ? ADDR_W'(rd_entry.addr) : '0;
  assign out_data = out_valid ? DATA_W'(rd_entry.data) : '0;
  assign count    = count_reg;
  assign ovf_err  = ovf_reg;

endmodule : addr_data_fifo

// File: tb/tb_addr_data_fifo.sv
// Directed bench for addr_data_fifo: a vector table plus hand sequences for
// full-with-pop, sustained streaming with wrap, and asynchronous reset.
module tb_addr_data_fifo;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic [DATA_W-1:0]      in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_W-1:0]      out_addr;
  logic [DATA_W-1:0]      out_data;
  logic [$clog2(DEPTH):0] count;
  logic                   ovf_err;
  logic                   clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  addr_data_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .count     (count),
    .ovf_err   (ovf_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ordy;
    logic        clr;
    int          e_cnt;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic iv, logic [31:0] a, logic [31:0] d, logic ordy,
                              logic clr, int ec, logic eov, logic eir,
                              logic [31:0] ea, logic [31:0] ed, logic eovf);
    vec_t v;
    v.iv = iv; v.addr = a; v.data = d; v.ordy = ordy; v.clr = clr;
    v.e_cnt = ec; v.e_ov = eov; v.e_ir = eir; v.e_addr = ea; v.e_data = ed; v.e_ovf = eovf;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic iv, logic [31:0] a, logic [31:0] d, logic ordy, logic clr);
    in_valid = iv; in_addr = a; in_data = d; out_ready = ordy; clr_err = clr;
  endtask

  task automatic chk_head(string tag, int ec, logic [31:0] ea, logic [31:0] ed);
    chk({tag, ".count"}, 64'(count), 64'(ec));
    chk({tag, ".out_addr"}, 64'(out_addr), 64'(ea));
    chk({tag, ".out_data"}, 64'(out_data), 64'(ed));
  endtask

  logic [31:0] q_addr[$];
  logic [31:0] a_tmp;

  initial begin
    // Pushes at 0x1000, pop, fill 0x0..0xC, overflow, clear tests, drain, push-at-empty.
    vecs[0]  = mk(1, 32'h1000, 32'hDEAD_BEEF, 0, 0, 1, 1, 1, 32'h1000, 32'hDEAD_BEEF, 0);
    vecs[1]  = mk(0, 32'h0,    32'h0,         1, 0, 0, 0, 1, 32'h0,    32'h0,         0);
    vecs[2]  = mk(1, 32'h0,    32'hA0,        0, 0, 1, 1, 1, 32'h0,    32'hA0,        0);
    vecs[3]  = mk(1, 32'h4,    32'hA1,        0, 0, 2, 1, 1, 32'h0,    32'hA0,        0);
    vecs[4]  = mk(1, 32'h8,    32'hA2,        0, 0, 3, 1, 1, 32'h0,    32'hA0,        0);
    vecs[5]  = mk(1, 32'hC,    32'hA3,        0, 0, 4, 1, 0, 32'h0,    32'hA0,        0);
    vecs[6]  = mk(1, 32'h10,   32'hFF,        0, 0, 4, 1, 0, 32'h0,    32'hA0,        1);
    vecs[7]  = mk(1, 32'h10,   32'hFF,        0, 1, 4, 1, 0, 32'h0,    32'hA0,        1);
    vecs[8]  = mk(0, 32'h0,    32'h0,         0, 1, 4, 1, 0, 32'h0,    32'hA0,        0);
    vecs[9]  = mk(0, 32'h0,    32'h0,         1, 0, 3, 1, 1, 32'h4,    32'hA1,        0);
    vecs[10] = mk(0, 32'h0,    32'h0,         1, 0, 2, 1, 1, 32'h8,    32'hA2,        0);
    vecs[11] = mk(0, 32'h0,    32'h0,         1, 0, 1, 1, 1, 32'hC,    32'hA3,        0);
    vecs[12] = mk(0, 32'h0,    32'h0,         1, 0, 0, 0, 1, 32'h0,    32'h0,         0);
    vecs[13] = mk(1, 32'h40,   32'hB0,        1, 0, 1, 1, 1, 32'h40,   32'hB0,        0);

    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.ovf_err", 64'(ovf_err), 64'd0);
    chk("reset.out_addr", 64'(out_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].iv, vecs[i].addr, vecs[i].data, vecs[i].ordy, vecs[i].clr);
      step();
      $display("row %0d: iv=%0b or=%0b clr=%0b -> count=%0d out_valid=%0b addr=%0h data=%0h ovf=%0b",
               i, vecs[i].iv, vecs[i].ordy, vecs[i].clr, count, out_valid, out_addr, out_data, ovf_err);
      chk($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
      chk($sformatf("vec%0d.out_addr", i), 64'(out_addr), 64'(vecs[i].e_addr));
      chk($sformatf("vec%0d.out_data", i), 64'(out_data), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d.ovf_err", i), 64'(ovf_err), 64'(vecs[i].e_ovf));
    end

    // Full FIFO: pop with in_valid high must not push that edge.
    for (int k = 1; k <= 3; k++) begin
      drive(1, 32'h40 + 32'(4 * k), 32'hB0 + 32'(k), 0, 0);
      step();
    end
    $display("fill: count=%0d in_ready=%0b", count, in_ready);
    chk("full.count", 64'(count), 64'd4);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    drive(1, 32'h50, 32'hB4, 1, 0);
    step();
    $display("full pop+valid: count=%0d head=%0h", count, out_addr);
    chk_head("fullpop", 3, 32'h44, 32'hB1);
    chk("fullpop.ovf_err", 64'(ovf_err), 64'd1);
    chk("fullpop.in_ready", 64'(in_ready), 64'd1);
    drive(1, 32'h50, 32'hB4, 0, 0);
    step();
    $display("retry push: count=%0d", count);
    chk("retry.count", 64'(count), 64'd4);
    for (int k = 2; k <= 4; k++) begin
      drive(0, 32'h0, 32'h0, 1, 1);
      step();
      $display("drain: count=%0d head=%0h", count, out_addr);
      chk_head($sformatf("fulldrain%0d", k), 4 - k + 1, 32'h40 + 32'(4 * k), 32'hB0 + 32'(k));
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    chk("fulldrain.empty", 64'(out_valid), 64'd0);
    chk("fulldrain.ovf_clr", 64'(ovf_err), 64'd0);

    // Streaming at count 2 for 20 cycles: both pointers wrap 5 times.
    q_addr.delete();
    for (int k = 0; k < 2; k++) begin
      a_tmp = 32'h200 + 32'(4 * k);
      drive(1, a_tmp, a_tmp ^ 32'h5A5A_0000, 0, 0);
      q_addr.push_back(a_tmp);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      a_tmp = 32'h208 + 32'(4 * k);
      drive(1, a_tmp, a_tmp ^ 32'h5A5A_0000, 1, 0);
      q_addr.push_back(a_tmp);
      void'(q_addr.pop_front());
      step();
      $display("stream %0d: count=%0d head=%0h", k, count, out_addr);
      chk_head($sformatf("stream%0d", k), 2, q_addr[0], q_addr[0] ^ 32'h5A5A_0000);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 32'h0, 32'h0, 1, 0);
      void'(q_addr.pop_front());
      step();
      if (k == 0) chk_head("streamdrain", 1, q_addr[0], q_addr[0] ^ 32'h5A5A_0000);
      else        chk_head("streamdrain", 0, 32'h0, 32'h0);
    end

    // Asynchronous reset mid-cycle with three entries stored.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h300 + 32'(4 * k), 32'hC0 + 32'(k), 0, 0);
      step();
    end
    chk("prerst.count", 64'(count), 64'd3);
    drive(0, 32'h0, 32'h0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    $display("async reset: count=%0d out_valid=%0b", count, out_valid);
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.in_ready", 64'(in_ready), 64'd1);
    chk("arst.out_addr", 64'(out_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h20, 32'h77, 0, 0);
    step();
    $display("post-reset push: count=%0d head=%0h", count, out_addr);
    chk_head("postrst", 1, 32'h20, 32'h77);
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    chk_head("postrst.pop", 0, 32'h0, 32'h0);
    chk("postrst.out_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_addr_data_fifo
